// File: rtl/gate_sweep_pkg.sv
// Shared types and sizing helpers for the gate sweep checker.
// Width helpers live here so every user of the checker sizes its counters identically.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    localparam int MAX_SETTLE = 255;
    localparam int SETTLE_W   = clog2(MAX_SETTLE + 1);

endpackage

// File: rtl/gate_sweep_checker.sv
// Exhaustively sweeps an N_IN-input function across N_IMPL parallel implementations
// and compares each output against a golden truth table after a settle delay.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_IMPL = 4,
    parameter int SETTLE = 1,
    parameter logic [vec_count(N_IN)-1:0] TRUTH = 4'b0111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_IMPL-1:0] y_impl,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IMPL-1:0] fail_mask,
    output logic [N_IN:0]     mismatch_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid,
    output state_t            fsm_state
);

    // Handshake: start is a level request accepted only in IDLE; busy covers the whole
    // sweep, done pulses for the single DONE cycle, and results hold until the next accept.

    state_t                state, state_next;
    logic [SETTLE_W-1:0]   settle_cnt, settle_cnt_next;
    logic [N_IN-1:0]       stim_next;
    logic                  busy_next, done_next, pass_next;
    logic [N_IMPL-1:0]     fail_mask_next;
    logic [N_IN:0]         mismatch_count_next;
    logic [N_IN-1:0]       first_fail_vec_next;
    logic                  first_fail_valid_next;
    logic [N_IMPL-1:0]     mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_mask        <= '0;
            mismatch_count   <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_next;
            settle_cnt       <= settle_cnt_next;
            stim             <= stim_next;
            busy             <= busy_next;
            done             <= done_next;
            pass             <= pass_next;
            fail_mask        <= fail_mask_next;
            mismatch_count   <= mismatch_count_next;
            first_fail_vec   <= first_fail_vec_next;
            first_fail_valid <= first_fail_valid_next;
        end
    end

    always_comb begin
        state_next            = state;
        settle_cnt_next       = settle_cnt;
        stim_next             = stim;
        busy_next             = busy;
        done_next             = 1'b0;
        pass_next             = pass;
        fail_mask_next        = fail_mask;
        mismatch_count_next   = mismatch_count;
        first_fail_vec_next   = first_fail_vec;
        first_fail_valid_next = first_fail_valid;
        mis                   = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next            = RUN;
                    stim_next             = '0;
                    settle_cnt_next       = SETTLE_W'(SETTLE);
                    busy_next             = 1'b1;
                    pass_next             = 1'b0;
                    fail_mask_next        = '0;
                    mismatch_count_next   = '0;
                    first_fail_vec_next   = '0;
                    first_fail_valid_next = 1'b0;
                end
            end
            RUN: begin
                if (settle_cnt != '0) begin
                    settle_cnt_next = settle_cnt - SETTLE_W'(1);
                end else begin
                    mis            = y_impl ^ {N_IMPL{TRUTH[stim]}};
                    fail_mask_next = fail_mask | mis;
                    if (|mis) begin
                        // A vector counts once however many implementations disagree.
                        mismatch_count_next = mismatch_count + (N_IN+1)'(1);
                        if (!first_fail_valid) begin
                            first_fail_vec_next   = stim;
                            first_fail_valid_next = 1'b1;
                        end
                    end
                    if (&stim) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        pass_next  = (fail_mask_next == '0);
                    end else begin
                        stim_next       = stim + N_IN'(1);
                        settle_cnt_next = SETTLE_W'(SETTLE);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: default NAND configuration plus a 3-input,
// zero-settle instance; expected timing and results are hand-derived per scenario.
module tb_gate_sweep_checker;
    import gate_sweep_pkg::*;

    logic       clk;
    logic       reset;
    logic       start_a;
    logic       start_b;

    logic [3:0] y_impl_a;
    logic [1:0] stim_a;
    logic       busy_a, done_a, pass_a, ffvalid_a;
    logic [3:0] mask_a;
    logic [2:0] count_a;
    logic [1:0] ffv_a;
    state_t     state_a;

    logic [1:0] y_impl_b;
    logic [2:0] stim_b;
    logic       busy_b, done_b, pass_b, ffvalid_b;
    logic [1:0] mask_b;
    logic [3:0] count_b;
    logic [2:0] ffv_b;
    state_t     state_b;

    // Implementation behaviours: 0 NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND.
    logic [1:0] mode_a [4];

    int passed;
    int total;

    gate_sweep_checker u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .y_impl(y_impl_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(mask_a), .mismatch_count(count_a), .first_fail_vec(ffv_a),
        .first_fail_valid(ffvalid_a), .fsm_state(state_a)
    );

    gate_sweep_checker #(.N_IN(3), .N_IMPL(2), .SETTLE(0), .TRUTH(8'h7F)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .y_impl(y_impl_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(mask_b), .mismatch_count(count_b), .first_fail_vec(ffv_b),
        .first_fail_valid(ffvalid_b), .fsm_state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            case (mode_a[k])
                2'd0:    y_impl_a[k] = ~&stim_a;
                2'd1:    y_impl_a[k] = 1'b1;
                2'd2:    y_impl_a[k] = 1'b0;
                default: y_impl_a[k] = &stim_a;
            endcase
        end
    end

    assign y_impl_b = {2{~&stim_b}};

    task automatic set_modes(input logic [1:0] m0, input logic [1:0] m1,
                             input logic [1:0] m2, input logic [1:0] m3);
        mode_a[0] = m0;
        mode_a[1] = m1;
        mode_a[2] = m2;
        mode_a[3] = m3;
    endtask

    // Returns at the negedge just after the accepting edge (cycle k=0).
    task automatic pulse_start_a;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        idle_cycles(3);
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else passed++;
        total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_a); else passed++;
        total++; if (stim_a !== 2'd0) $display("FAIL reset_stim: got %0d expected 0", stim_a); else passed++;
        total++; if ({pass_a, mask_a, count_a, ffv_a, ffvalid_a} !== 11'd0)
            $display("FAIL reset_results: got %b expected all zero", {pass_a, mask_a, count_a, ffv_a, ffvalid_a}); else passed++;
        total++; if (state_a !== IDLE) $display("FAIL reset_state: got %0d expected %0d", state_a, IDLE); else passed++;
        total++; if ({busy_b, done_b, pass_b, stim_b, mask_b, count_b, ffvalid_b} !== 14'd0)
            $display("FAIL reset_b: got %b expected all zero", {busy_b, done_b, pass_b, stim_b, mask_b, count_b, ffvalid_b}); else passed++;
        reset = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_clean_sweep;
        logic [1:0] exp_stim;
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        pulse_start_a();
        for (int k = 0; k <= 9; k++) begin
            exp_stim = (k < 8) ? 2'(k / 2) : 2'd3;
            total++; if (stim_a !== exp_stim) $display("FAIL clean_stim k=%0d: got %0d expected %0d", k, stim_a, exp_stim); else passed++;
            total++; if (busy_a !== (k < 8)) $display("FAIL clean_busy k=%0d: got %b expected %b", k, busy_a, (k < 8)); else passed++;
            total++; if (done_a !== (k == 8)) $display("FAIL clean_done k=%0d: got %b expected %b", k, done_a, (k == 8)); else passed++;
            if (k == 8) begin
                total++; if (pass_a !== 1'b1) $display("FAIL clean_pass: got %b expected 1", pass_a); else passed++;
                total++; if (mask_a !== 4'b0000) $display("FAIL clean_mask: got %b expected 0000", mask_a); else passed++;
                total++; if (count_a !== 3'd0) $display("FAIL clean_count: got %0d expected 0", count_a); else passed++;
                total++; if (ffvalid_a !== 1'b0) $display("FAIL clean_ffvalid: got %b expected 0", ffvalid_a); else passed++;
            end
            if (k == 9) begin
                total++; if (state_a !== IDLE) $display("FAIL clean_idle: got %0d expected %0d", state_a, IDLE); else passed++;
                total++; if (pass_a !== 1'b1) $display("FAIL clean_pass_hold: got %b expected 1", pass_a); else passed++;
            end
            @(negedge clk);
        end
        idle_cycles(1);
    endtask

    task automatic test_stuck_high;
        set_modes(2'd0, 2'd0, 2'd1, 2'd0);
        pulse_start_a();
        idle_cycles(8);
        total++; if (done_a !== 1'b1) $display("FAIL stuck1_done: got %b expected 1", done_a); else passed++;
        total++; if (mask_a !== 4'b0100) $display("FAIL stuck1_mask: got %b expected 0100", mask_a); else passed++;
        total++; if (count_a !== 3'd1) $display("FAIL stuck1_count: got %0d expected 1", count_a); else passed++;
        total++; if (ffv_a !== 2'b11) $display("FAIL stuck1_ffv: got %b expected 11", ffv_a); else passed++;
        total++; if (ffvalid_a !== 1'b1) $display("FAIL stuck1_ffvalid: got %b expected 1", ffvalid_a); else passed++;
        total++; if (pass_a !== 1'b0) $display("FAIL stuck1_pass: got %b expected 0", pass_a); else passed++;
        idle_cycles(3);
        total++; if ({mask_a, count_a, ffv_a} !== {4'b0100, 3'd1, 2'b11})
            $display("FAIL stuck1_hold: got %b expected %b", {mask_a, count_a, ffv_a}, {4'b0100, 3'd1, 2'b11}); else passed++;
    endtask

    task automatic test_multi_fail;
        set_modes(2'd0, 2'd3, 2'd0, 2'd2);
        pulse_start_a();
        idle_cycles(8);
        total++; if (done_a !== 1'b1) $display("FAIL multi_done: got %b expected 1", done_a); else passed++;
        total++; if (mask_a !== 4'b1010) $display("FAIL multi_mask: got %b expected 1010", mask_a); else passed++;
        total++; if (count_a !== 3'd4) $display("FAIL multi_count: got %0d expected 4", count_a); else passed++;
        total++; if (ffv_a !== 2'b00) $display("FAIL multi_ffv: got %b expected 00", ffv_a); else passed++;
        total++; if (ffvalid_a !== 1'b1) $display("FAIL multi_ffvalid: got %b expected 1", ffvalid_a); else passed++;
        total++; if (pass_a !== 1'b0) $display("FAIL multi_pass: got %b expected 0", pass_a); else passed++;
        idle_cycles(3);
    endtask

    task automatic test_reset_mid_sweep;
        int done_seen;
        set_modes(2'd0, 2'd0, 2'd0, 2'd2);
        pulse_start_a();
        idle_cycles(2);
        total++; if ({ffvalid_a, mask_a} !== 5'b1_1000) $display("FAIL midreset_pre: got %b expected 11000", {ffvalid_a, mask_a}); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy_a !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy_a); else passed++;
        total++; if (stim_a !== 2'd0) $display("FAIL midreset_stim: got %0d expected 0", stim_a); else passed++;
        total++; if ({pass_a, mask_a, count_a, ffv_a, ffvalid_a} !== 11'd0)
            $display("FAIL midreset_results: got %b expected all zero", {pass_a, mask_a, count_a, ffv_a, ffvalid_a}); else passed++;
        total++; if (state_a !== IDLE) $display("FAIL midreset_state: got %0d expected %0d", state_a, IDLE); else passed++;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (done_a === 1'b1) done_seen++;
            @(negedge clk);
        end
        total++; if (done_seen !== 0) $display("FAIL midreset_nodone: got %0d done cycles expected 0", done_seen); else passed++;
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        pulse_start_a();
        idle_cycles(8);
        total++; if ({done_a, pass_a, mask_a, count_a} !== {1'b1, 1'b1, 4'b0000, 3'd0})
            $display("FAIL midreset_rerun: got %b expected %b", {done_a, pass_a, mask_a, count_a}, {1'b1, 1'b1, 4'b0000, 3'd0}); else passed++;
        idle_cycles(3);
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_stim;
        int m;
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        pulse_start_a();
        for (int k = 0; k <= 9; k++) begin
            if (k == 3) start_a = 1'b1;
            if (k == 4) start_a = 1'b0;
            exp_stim = (k < 8) ? 2'(k / 2) : 2'd3;
            total++; if (stim_a !== exp_stim) $display("FAIL midstart_stim k=%0d: got %0d expected %0d", k, stim_a, exp_stim); else passed++;
            total++; if (done_a !== (k == 8)) $display("FAIL midstart_done k=%0d: got %b expected %b", k, done_a, (k == 8)); else passed++;
            @(negedge clk);
        end
        start_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            m = k % 10;
            exp_stim = (m < 8) ? 2'(m / 2) : 2'd3;
            total++; if (busy_a !== (m < 8)) $display("FAIL held_busy k=%0d: got %b expected %b", k, busy_a, (m < 8)); else passed++;
            total++; if (done_a !== (m == 8)) $display("FAIL held_done k=%0d: got %b expected %b", k, done_a, (m == 8)); else passed++;
            total++; if (stim_a !== exp_stim) $display("FAIL held_stim k=%0d: got %0d expected %0d", k, stim_a, exp_stim); else passed++;
            if (k == 19) start_a = 1'b0;
            @(negedge clk);
        end
        total++; if ({state_a, busy_a} !== {IDLE, 1'b0}) $display("FAIL held_release: got %b expected %b", {state_a, busy_a}, {IDLE, 1'b0}); else passed++;
        idle_cycles(2);
    endtask

    task automatic test_wide_zero_settle;
        logic [2:0] exp_stim;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            exp_stim = (k < 8) ? 3'(k) : 3'd7;
            total++; if (stim_b !== exp_stim) $display("FAIL wide_stim k=%0d: got %0d expected %0d", k, stim_b, exp_stim); else passed++;
            total++; if (busy_b !== (k < 8)) $display("FAIL wide_busy k=%0d: got %b expected %b", k, busy_b, (k < 8)); else passed++;
            total++; if (done_b !== (k == 8)) $display("FAIL wide_done k=%0d: got %b expected %b", k, done_b, (k == 8)); else passed++;
            if (k == 8) begin
                total++; if ({pass_b, mask_b, count_b, ffvalid_b} !== {1'b1, 2'b00, 4'd0, 1'b0})
                    $display("FAIL wide_results: got %b expected %b", {pass_b, mask_b, count_b, ffvalid_b}, {1'b1, 2'b00, 4'd0, 1'b0}); else passed++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        passed = 0;
        total = 0;
        set_modes(2'd0, 2'd0, 2'd0, 2'd0);
        test_reset();
        test_clean_sweep();
        test_stuck_high();
        test_multi_fail();
        test_reset_mid_sweep();
        test_back_to_back();
        test_wide_zero_settle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
